// File: rtl/cache_pkg.sv
// Shared types and defaults for the data-cache sequencing controller.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;
  localparam int DEFAULT_WORDS_PER_BLOCK = 4;
  localparam int DEFAULT_IDX_W           = $clog2(DEFAULT_WORDS_PER_BLOCK);
endpackage

// File: rtl/cache_if.sv
// Core/array/memory handshake bundle seen by the cache controller.
interface cache_if #(
  parameter int IDX_W = cache_pkg::DEFAULT_IDX_W
) ();
  logic             MemRead;
  logic             MemWrite;
  logic             Hit;
  logic             mem_ready;
  logic             stall;
  logic             mem_rd_req;
  logic             mem_wr_req;
  logic             refill_we;
  logic [IDX_W-1:0] refill_idx;
  logic             refill_done;
  logic             cache_wr_en;

  modport slave (
    input  MemRead, MemWrite, Hit, mem_ready,
    output stall, mem_rd_req, mem_wr_req, refill_we, refill_idx, refill_done, cache_wr_en
  );

  modport master (
    output MemRead, MemWrite, Hit, mem_ready,
    input  stall, mem_rd_req, mem_wr_req, refill_we, refill_idx, refill_done, cache_wr_en
  );
endinterface

// File: rtl/cache_perf_counter.sv
// Free-running event counter, wraps modulo 2^CNT_W.
module cache_perf_counter
  import cache_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb count_d = count_q + CNT_W'(inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache sequencer:
// stalls the core for block refills on read misses and for every store.
module cache_controller
  import cache_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_if.slave           bus,
  output logic [CNT_W-1:0] access_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] refill_idx_q, refill_idx_d;
  logic stall, rd_req, wr_req, we, done, cwe, acc_inc, miss_inc;

  always_comb begin
    state_d      = state_q;
    refill_idx_d = refill_idx_q;
    stall    = 1'b0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    we       = 1'b0;
    done     = 1'b0;
    cwe      = 1'b0;
    acc_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state_q)
      IDLE: begin
        // Stores win over loads; the cached word is updated only on entry.
        if (bus.MemWrite) begin
          stall   = 1'b1;
          cwe     = bus.Hit;
          state_d = WRITE;
        end else if (bus.MemRead) begin
          if (bus.Hit) begin
            acc_inc = 1'b1;
          end else begin
            stall        = 1'b1;
            miss_inc     = 1'b1;
            refill_idx_d = '0;
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        stall  = 1'b1;
        rd_req = 1'b1;
        if (bus.mem_ready) begin
          we           = 1'b1;
          refill_idx_d = refill_idx_q + IDX_W'(1);
          if (refill_idx_q == LAST_IDX) begin
            done         = 1'b1;
            refill_idx_d = '0;
            state_d      = IDLE;
          end
        end
      end
      WRITE: begin
        wr_req = 1'b1;
        stall  = !bus.mem_ready;
        if (bus.mem_ready) begin
          acc_inc = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      refill_idx_q <= '0;
    end else begin
      state_q      <= state_d;
      refill_idx_q <= refill_idx_d;
    end
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign bus.stall       = rst_n & stall;
  assign bus.mem_rd_req  = rst_n & rd_req;
  assign bus.mem_wr_req  = rst_n & wr_req;
  assign bus.refill_we   = rst_n & we;
  assign bus.refill_done = rst_n & done;
  assign bus.cache_wr_en = rst_n & cwe;
  assign bus.refill_idx  = rst_n ? refill_idx_q : '0;

  cache_perf_counter #(.CNT_W(CNT_W)) u_access_cnt (
    .clk(clk), .rst_n(rst_n), .inc(acc_inc), .count(access_cnt)
  );

  cache_perf_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk(clk), .rst_n(rst_n), .inc(miss_inc), .count(miss_cnt)
  );
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing FSM for the data cache of the single-cycle RISC-V core; sits between the core control signals (MemRead, MemWrite), the cache tag/data arrays and main memory.
- Cache organisation: direct-mapped, write-through, no-write-allocate.
- On a read miss it stalls the core and refills a whole block word-by-word over a ready handshake.
- On any store it stalls the core until main memory accepts the write.
- Keeps access and miss performance counters.

Parameters:
- WORDS_PER_BLOCK, 4, words per cache block; power of two, >=2.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- MemRead  input  1  load in the current instruction.
- MemWrite  input  1  store in the current instruction.
- Hit  input  1  valid & tag match from the tag array, combinational.
- mem_ready  input  1  main memory completes the current word transfer this cycle.
- stall  output  1  freezes PC and pipeline registers.
- mem_rd_req  output  1  block-refill read request to main memory.
- mem_wr_req  output  1  write-through request to main memory.
- refill_we  output  1  write the returned memory word into the data array.
- refill_idx  output  log2(WORDS_PER_BLOCK)  word offset of the current refill beat.
- refill_done  output  1  set valid bit and write tag for the indexed line.
- cache_wr_en  output  1  store-hit update of the cached word.
- access_cnt  output  CNT_W  completed memory accesses.
- miss_cnt  output  CNT_W  read misses.

Behaviour:
- States: IDLE, REFILL, WRITE.
- Registers: state, refill_idx, both counters.
- All other outputs are combinational from state and inputs.
- Reset:
  - state=IDLE, refill_idx=0, access_cnt=0, miss_cnt=0.
  - While rst_n=0, every output is 0.
- IDLE:
  - MemWrite=1: stall=1, cache_wr_en=Hit for this one cycle only, next state WRITE. MemWrite has priority if MemRead is also 1.
  - MemRead=1 and Hit=1: stall=0, stay in IDLE, access_cnt+1.
  - MemRead=1 and Hit=0: stall=1, next state REFILL, refill_idx<=0, miss_cnt+1.
  - No access: stall=0, all requests 0.
- REFILL:
  - stall=1 and mem_rd_req=1 throughout.
  - mem_ready=1: refill_we=1 this cycle; refill_idx increments at the clock edge.
  - mem_ready=1 with refill_idx==WORDS_PER_BLOCK-1: refill_done=1 the same cycle, refill_idx wraps to 0, next state IDLE.
  - Back in IDLE, the same load re-evaluates, sees Hit=1 and completes. Minimum miss penalty is WORDS_PER_BLOCK+1 stall cycles.
- WRITE:
  - mem_wr_req=1, stall=!mem_ready.
  - mem_ready=1: access_cnt+1, next state IDLE. The core advances on that same edge, so the next instruction is seen in IDLE.
- Counters: wrap modulo 2^CNT_W; no saturation.
- mem_ready in IDLE is ignored.
- Reset mid-refill:
  - Immediate abort to IDLE; refill_done is never issued.
  - The line's valid bit is not set, so partially written words are harmless.
- cache_wr_en and refill_we are never asserted in the same cycle.

Decomposition:
- Shared package cache_pkg holds:
  - state enum (IDLE, REFILL, WRITE);
  - WORDS_PER_BLOCK default;
  - derived IDX_W = log2(WORDS_PER_BLOCK).
- One sub-module, cache_perf_counter:
  - inputs clk, rst_n, inc;
  - output count [CNT_W];
  - two instances, one for access_cnt and one for miss_cnt.

Test Plan:
- Read hit: MemRead=1, Hit=1 in IDLE -> stall=0 that cycle; access_cnt 0->1; miss_cnt stays 0.
- Read miss, mem_ready held 1:
  - MemRead=1, Hit=0 -> stall high for 5 cycles;
  - refill_we pulses with refill_idx 0,1,2,3; refill_done coincides with idx 3;
  - Hit raised next cycle -> stall=0; miss_cnt=1, access_cnt=1.
- Refill under back-pressure: mem_ready toggles 0/1 every cycle during a miss -> refill_idx advances only on ready cycles; refill_done after exactly 4 ready beats; stall held throughout.
- Store hit with mem_ready asserted 3 cycles after entry:
  - cache_wr_en=1 only in the IDLE cycle;
  - mem_wr_req high 3 cycles, stall drops in the mem_ready cycle;
  - access_cnt+1.
- Store miss, and MemRead=MemWrite=1 simultaneously -> cache_wr_en=0, WRITE path taken, no refill.
- Reset mid-refill: rst_n low after refill_idx=2 -> all outputs 0 immediately; after release state=IDLE, refill_idx=0, counters 0, no refill_done seen. Separately, preload miss_cnt to 2^CNT_W-1 and miss -> count wraps to 0.
